alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, giving the number of EXEC cycles for non-MUL/DIV operations (legal range 1..15).
REQ-002 SHALL have parameter MULDIV_CYCLES, default 4, giving the number of EXEC cycles for MUL, MULC, DIV and DIVC (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port instr_valid, input, 1 bit: an instruction word is offered.
REQ-006 SHALL have port instr_ready, output, 1 bit: the block can accept an instruction.
REQ-007 SHALL have port instr, input, 32 bits: instruction word; opcode [31:26], rc [25:21], ra [20:16], rb [15:11], literal [15:0].
REQ-008 SHALL have ports ra_addr and rb_addr, output, 5 bits each: register-file read addresses.
REQ-009 SHALL have ports ra_data and rb_data, input, 32 bits each: combinational register-file read data.
REQ-010 SHALL have ports alu_a and alu_b (output, 32 bits) and alu_fn (output, 6 bits): operands and function code to the ALU, with alu_fn using the alu_* constants in risc_constants.vh.
REQ-011 SHALL have port alu_result, input, 32 bits: combinational ALU output.
REQ-012 SHALL have ports wr_en (output, 1 bit), wr_addr (output, 5 bits) and wr_data (output, 32 bits): register-file write port.
REQ-013 SHALL have ports illegal (output, 1 bit: one-cycle fault pulse) and busy (output, 1 bit: high in any state other than IDLE).

Function
REQ-014 SHALL implement the FSM states IDLE, DECODE, EXEC and WB, and SHALL drive instr_ready = 1 only in IDLE.
REQ-015 SHALL, when instr_valid && instr_ready at a clock edge, latch instr and go to DECODE; instr_valid without instr_ready SHALL be ignored, and instr SHALL be sampled only at acceptance.
REQ-016 SHALL, in DECODE, map each legal opcode to alu_fn and operand-select and hold that mapping until the block returns to IDLE: register forms are 0x20 ADD, 0x21 SUB, 0x22 MUL, 0x23 DIV, 0x24 CMPEQ, 0x25 CMPLT, 0x26 CMPLE, 0x28 AND, 0x29 OR, 0x2A XOR, 0x2B XNOR, 0x2C SHL, 0x2D SHR, 0x2E SRA, and each constant form is the register opcode + 0x10.
REQ-017 SHALL, for any other opcode, pulse illegal for exactly one cycle in the cycle after DECODE, return to IDLE and never assert wr_en for that instruction.
REQ-018 SHALL drive ra_addr and rb_addr from the latched ra and rb fields from DECODE through WB.
REQ-019 SHALL drive alu_a = 0 when ra == 31, and ra_data otherwise.
REQ-020 SHALL drive alu_b as the literal sign-extended to 32 bits for constant forms; for register forms, alu_b = 0 when rb == 31, and rb_data otherwise.
REQ-021 SHALL, for SHL, SHR and SRA (register or constant form), drive alu_b = {27'b0, b[4:0]}.
REQ-022 SHALL stay in EXEC for exactly MULDIV_CYCLES cycles for MUL/MULC/DIV/DIVC and exactly EXEC_CYCLES cycles otherwise, using a down-counter loaded on DECODE->EXEC, and hold alu_a, alu_b and alu_fn stable throughout EXEC.
REQ-023 SHALL register alu_result into wr_data on the last EXEC cycle, then enter WB.
REQ-024 SHALL treat DIV or DIVC with an effective divisor of 0 as a fault: pulse illegal in the WB cycle and suppress wr_en.
REQ-025 SHALL, in WB, assert wr_en for exactly one cycle with wr_addr = rc, except that wr_en SHALL stay 0 when rc == 31; WB SHALL always be followed by IDLE.
REQ-026 SHALL give a latency, with the accept edge as cycle 0, of WB = cycle N+2 where N is the EXEC cycle count, with instr_ready high again in cycle N+3.
REQ-027 SHALL keep at most one instruction in flight, with no overlap or bypass.

Reset
REQ-028 SHALL, while rst_n = 0 (asynchronous, independent of clk), force state = IDLE, instr_ready = 1, busy = 0, wr_en = 0, illegal = 0, wr_addr = 0, wr_data = 0, ra_addr = 0, rb_addr = 0, alu_a = 0, alu_b = 0, alu_fn = 0, and clear the EXEC counter.
REQ-029 SHALL abandon any in-flight instruction when reset is asserted in DECODE, EXEC or WB, with no wr_en or illegal pulse afterward for that instruction.
REQ-030 SHALL accept an instruction presented on the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL verify ADD: instr 0x80611000 with R1 = 5, R2 = 7 and defaults -> alu_fn = alu_ADD, then a single wr_en in cycle 3 with wr_addr = 3, wr_data = 12.
REQ-032 SHALL verify SUBC: instr 0xC481FFFF with R1 = 5 -> alu_b = 0xFFFFFFFF, wr_addr = 4, wr_data = 6.
REQ-033 SHALL verify MUL timing: instr 0x88611000 with R1 = 3, R2 = -4 and MULDIV_CYCLES = 4 -> 4 EXEC cycles, wr_en in cycle 6, wr_data = 0xFFFFFFF4.
REQ-034 SHALL verify faults: instr 0x00000000 -> illegal pulsed in cycle 2 and no wr_en; instr 0x8CA11000 with R2 = 0 -> illegal pulsed in WB and no wr_en.
REQ-035 SHALL verify R31 handling: instr 0x83E11000 (rc = 31) -> wr_en stays 0 and instr_ready returns in cycle 4; ra = 31 with ra_data = 0xDEAD -> alu_a = 0.
REQ-036 SHALL verify mid-operation reset: rst_n pulsed low in the second EXEC cycle of a MUL -> immediate IDLE, instr_ready = 1, and no later wr_en or illegal pulse.

Source files
------------

// File: rtl/alu_issue.sv
// Single-issue ALU sequencer: accepts one instruction, decodes it, drives the
// ALU for a fixed number of EXEC cycles and writes the result back.
module alu_issue #(
  parameter int unsigned EXEC_CYCLES   = 1,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  ra_addr,
  output logic [4:0]  rb_addr,
  input  logic [31:0] ra_data,
  input  logic [31:0] rb_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fn,
  input  logic [31:0] alu_result,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        illegal,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for an instruction, instr_ready high
  // DECODE | opcode decoded, operands selected
  // EXEC   | ALU operands held while the counter runs down
  // WB     | register-file write (or divide-by-zero fault) cycle

  localparam logic [5:0] alu_ADD   = 6'h20;
  localparam logic [5:0] alu_SUB   = 6'h21;
  localparam logic [5:0] alu_MUL   = 6'h22;
  localparam logic [5:0] alu_DIV   = 6'h23;
  localparam logic [5:0] alu_CMPEQ = 6'h24;
  localparam logic [5:0] alu_CMPLT = 6'h25;
  localparam logic [5:0] alu_CMPLE = 6'h26;
  localparam logic [5:0] alu_AND   = 6'h28;
  localparam logic [5:0] alu_OR    = 6'h29;
  localparam logic [5:0] alu_XOR   = 6'h2A;
  localparam logic [5:0] alu_XNOR  = 6'h2B;
  localparam logic [5:0] alu_SHL   = 6'h2C;
  localparam logic [5:0] alu_SHR   = 6'h2D;
  localparam logic [5:0] alu_SRA   = 6'h2E;

  localparam logic [3:0] EXEC_LOAD   = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t      state, state_nxt;
  logic [31:0] instr_q;
  logic [3:0]  cnt, cnt_nxt;
  logic        wr_en_q, illegal_q, wr_set, ill_set, load_wb;
  logic [31:0] wr_data_q;

  logic        active, legal, is_const, is_shift, is_muldiv, is_div, div_zero;
  logic [5:0]  fn_dec;
  logic [4:0]  rc, ra, rb;
  logic [31:0] b_raw, b_eff;

  assign active   = (state != IDLE);
  assign rc       = instr_q[25:21];
  assign ra       = instr_q[20:16];
  assign rb       = instr_q[15:11];
  assign is_const = instr_q[30];

  always_comb begin
    fn_dec    = alu_ADD;
    legal     = instr_q[31];
    is_shift  = 1'b0;
    is_muldiv = 1'b0;
    is_div    = 1'b0;
    case (instr_q[29:26])
      4'h0: fn_dec = alu_ADD;
      4'h1: fn_dec = alu_SUB;
      4'h2: begin fn_dec = alu_MUL; is_muldiv = 1'b1; end
      4'h3: begin fn_dec = alu_DIV; is_muldiv = 1'b1; is_div = 1'b1; end
      4'h4: fn_dec = alu_CMPEQ;
      4'h5: fn_dec = alu_CMPLT;
      4'h6: fn_dec = alu_CMPLE;
      4'h8: fn_dec = alu_AND;
      4'h9: fn_dec = alu_OR;
      4'hA: fn_dec = alu_XOR;
      4'hB: fn_dec = alu_XNOR;
      4'hC: begin fn_dec = alu_SHL; is_shift = 1'b1; end
      4'hD: begin fn_dec = alu_SHR; is_shift = 1'b1; end
      4'hE: begin fn_dec = alu_SRA; is_shift = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  assign b_raw    = is_const ? {{16{instr_q[15]}}, instr_q[15:0]}
                             : ((rb == 5'd31) ? 32'd0 : rb_data);
  assign b_eff    = is_shift ? {27'd0, b_raw[4:0]} : b_raw;
  assign div_zero = is_div && (b_eff == 32'd0);

  // Operand paths are forced to zero in IDLE so reset shows a clean bus.
  assign ra_addr = active ? ra : 5'd0;
  assign rb_addr = active ? rb : 5'd0;
  assign alu_a   = (active && ra != 5'd31) ? ra_data : 32'd0;
  assign alu_b   = active ? b_eff : 32'd0;
  assign alu_fn  = (active && legal) ? fn_dec : 6'd0;
  assign wr_addr = active ? rc : 5'd0;

  assign instr_ready = (state == IDLE);
  assign busy        = active;
  assign wr_en       = wr_en_q;
  assign illegal     = illegal_q;
  assign wr_data     = wr_data_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_set    = 1'b0;
    ill_set   = 1'b0;
    load_wb   = 1'b0;
    case (state)
      IDLE: if (instr_valid) state_nxt = DECODE;
      DECODE: begin
        if (!legal) begin
          ill_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = is_muldiv ? MULDIV_LOAD : EXEC_LOAD;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          load_wb   = 1'b1;
          ill_set   = div_zero;
          wr_set    = !div_zero && (rc != 5'd31);
          state_nxt = WB;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WB: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      instr_q   <= 32'd0;
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      wr_data_q <= 32'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wr_en_q   <= wr_set;
      illegal_q <= ill_set;
      if (state == IDLE && instr_valid) instr_q <= instr;
      if (load_wb) wr_data_q <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed vector bench for alu_issue with a behavioural register file and ALU.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'd0;
  logic [4:0]  ra_addr, rb_addr;
  logic [31:0] ra_data, rb_data;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_fn;
  logic [31:0] alu_result;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        illegal, busy;

  logic [31:0] r1 = 32'd0, r2 = 32'd0;
  int n_pass = 0, n_total = 0;

  alu_issue #(.EXEC_CYCLES(1), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data),
    .rb_data(rb_data), .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn),
    .alu_result(alu_result), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    case (a)
      5'd1:    return r1;
      5'd2:    return r2;
      5'd31:   return 32'h0000DEAD;
      default: return 32'd0;
    endcase
  endfunction

  assign ra_data = rf_read(ra_addr);
  assign rb_data = rf_read(rb_addr);

  always_comb begin
    alu_result = 32'd0;
    case (alu_fn)
      6'h20: alu_result = alu_a + alu_b;
      6'h21: alu_result = alu_a - alu_b;
      6'h22: alu_result = alu_a * alu_b;
      6'h23: alu_result = (alu_b == 32'd0) ? 32'd0 : 32'($signed(alu_a) / $signed(alu_b));
      6'h24: alu_result = {31'd0, alu_a == alu_b};
      6'h25: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      6'h26: alu_result = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      6'h28: alu_result = alu_a & alu_b;
      6'h29: alu_result = alu_a | alu_b;
      6'h2A: alu_result = alu_a ^ alu_b;
      6'h2B: alu_result = ~(alu_a ^ alu_b);
      6'h2C: alu_result = alu_a << alu_b[4:0];
      6'h2D: alu_result = alu_a >> alu_b[4:0];
      6'h2E: alu_result = 32'($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r1, r2;
    logic [5:0]  fn;
    logic [31:0] a, b;
    int          wr_cyc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          ill_cyc;
    int          rdy_cyc;
  } vec_t;

  vec_t vecs[12];

  // Cycle k is the period ending at the k-th edge after the accept edge.
  task automatic run_vec(input int idx, input vec_t v);
    int wr_n = 0, ill_n = 0, ill_at = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    r1 = v.r1;
    r2 = v.r2;
    instr = v.instr;
    instr_valid = 1'b1;
    for (int k = 1; k <= v.rdy_cyc; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, " busy"}, {31'd0, busy}, 32'd1);
      if (v.ill_cyc != 2 && (k == 2 || k == v.rdy_cyc - 2)) begin
        check($sformatf("%s alu_fn c%0d", tag, k), {26'd0, alu_fn}, {26'd0, v.fn});
        check($sformatf("%s alu_a c%0d", tag, k), alu_a, v.a);
        check($sformatf("%s alu_b c%0d", tag, k), alu_b, v.b);
      end
      if (k == v.rdy_cyc - 1) check({tag, " ready low"}, {31'd0, instr_ready}, 32'd0);
      if (k == v.rdy_cyc) check({tag, " ready back"}, {31'd0, instr_ready}, 32'd1);
      if (wr_en) begin
        wr_n++;
        check($sformatf("%s wr_en cycle", tag), k, v.wr_cyc);
        check({tag, " wr_addr"}, {27'd0, wr_addr}, {27'd0, v.waddr});
        check({tag, " wr_data"}, wr_data, v.wdata);
      end
      if (illegal) begin
        ill_n++;
        ill_at = k;
      end
      // Junk offered while busy must be ignored.
      instr = 32'h0;
      instr_valid = (k < v.rdy_cyc);
    end
    check({tag, " wr_en count"}, wr_n, (v.wr_cyc != 0) ? 1 : 0);
    check({tag, " illegal count"}, ill_n, (v.ill_cyc != 0) ? 1 : 0);
    check({tag, " illegal cycle"}, ill_at, v.ill_cyc);
  endtask

  initial begin
    int wr_n, ill_n;
    bit seen;
    vecs[0]  = '{32'h80611000, 32'd5, 32'd7, 6'h20, 32'd5, 32'd7, 3, 5'd3, 32'd12, 0, 4};
    vecs[1]  = '{32'hC481FFFF, 32'd5, 32'd7, 6'h21, 32'd5, 32'hFFFFFFFF, 3, 5'd4, 32'd6, 0, 4};
    vecs[2]  = '{32'h88611000, 32'd3, 32'hFFFFFFFC, 6'h22, 32'd3, 32'hFFFFFFFC, 6, 5'd3, 32'hFFFFFFF4, 0, 7};
    vecs[3]  = '{32'h00000000, 32'd5, 32'd7, 6'h00, 32'd0, 32'd0, 0, 5'd0, 32'd0, 2, 2};
    vecs[4]  = '{32'h8CA11000, 32'd5, 32'd0, 6'h23, 32'd5, 32'd0, 0, 5'd0, 32'd0, 6, 7};
    vecs[5]  = '{32'h83E11000, 32'd5, 32'd7, 6'h20, 32'd5, 32'd7, 0, 5'd0, 32'd0, 0, 4};
    vecs[6]  = '{32'h807F1000, 32'd5, 32'd7, 6'h20, 32'd0, 32'd7, 3, 5'd3, 32'd7, 0, 4};
    vecs[7]  = '{32'hF0C10023, 32'd5, 32'd7, 6'h2C, 32'd5, 32'd3, 3, 5'd6, 32'h28, 0, 4};
    vecs[8]  = '{32'hB8E20800, 32'h21, 32'hFFFFFFF0, 6'h2E, 32'hFFFFFFF0, 32'd1, 3, 5'd7, 32'hFFFFFFF8, 0, 4};
    vecs[9]  = '{32'hD501FFFE, 32'hFFFFFFFD, 32'd0, 6'h25, 32'hFFFFFFFD, 32'hFFFFFFFE, 3, 5'd8, 32'd1, 0, 4};
    vecs[10] = '{32'h9C000000, 32'd5, 32'd7, 6'h00, 32'd0, 32'd0, 0, 5'd0, 32'd0, 2, 2};
    vecs[11] = '{32'h8CA11000, 32'hFFFFFFF9, 32'd2, 6'h23, 32'hFFFFFFF9, 32'd2, 6, 5'd5, 32'hFFFFFFFD, 0, 7};

    instr_valid = 1'b1;
    instr = 32'h80611000;
    repeat (3) @(negedge clk);
    check("rst instr_ready", {31'd0, instr_ready}, 32'd1);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst wr_en", {31'd0, wr_en}, 32'd0);
    check("rst illegal", {31'd0, illegal}, 32'd0);
    check("rst wr_data", wr_data, 32'd0);
    check("rst alu_fn", {26'd0, alu_fn}, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst ra_addr", {27'd0, ra_addr}, 32'd0);
    instr_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset during the second EXEC cycle of a MUL abandons it.
    @(negedge clk);
    r1 = 32'd3;
    r2 = 32'hFFFFFFFC;
    instr = 32'h88611000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst instr_ready", {31'd0, instr_ready}, 32'd1);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst alu_fn", {26'd0, alu_fn}, 32'd0);
    check("midrst alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_n = 0;
    ill_n = 0;
    repeat (8) begin
      @(negedge clk);
      if (wr_en) wr_n++;
      if (illegal) ill_n++;
    end
    check("midrst no wr_en", wr_n, 0);
    check("midrst no illegal", ill_n, 0);

    // Instruction presented with reset release is taken on the first edge.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r1 = 32'd5;
    r2 = 32'd7;
    instr = 32'h80611000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check("postrst accepted", {31'd0, busy}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (wr_en) begin
        seen = 1'b1;
        check("postrst wr_data", wr_data, 32'd12);
      end
    end
    check("postrst wr_en seen", {31'd0, seen}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
